pwqe_slot_mgr: RTL and testbench

PWQE_SLOT_MGR -- requirements
Module: pwqe_slot_mgr

---
 rtl/pwqe_slot_mgr.sv | 174 +++++++++++++++++
 tb/tb_pwqe_slot_mgr.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwqe_slot_mgr.sv
`default_nettype none
// ============================================================================
// Module   : pwqe_slot_mgr
// Purpose  : Station-buffer slot allocator. Fills FREE slots from the WQE FIFO
//            and tracks each slot through READY / INFLIGHT / writeback.
// Revision : 1.0 - initial release
// ============================================================================
module pwqe_slot_mgr #(
   parameter int WQE_WIDTH           = 512,
   parameter int PWQE_SLOT_NUM       = 4,
   parameter int PWQE_BUF_ADDR_WIDTH = 2
) (
   input  logic                             sys_clk,
   input  logic                             sys_rst,
   input  logic                             i_fill_en,
   input  logic                             i_bs_wqe_empty,
   output logic                             o_bs_wqe_ren,
   input  logic [WQE_WIDTH-1:0]             i_bs_wqe_rdata,
   output logic                             o_wen_0,
   output logic [PWQE_BUF_ADDR_WIDTH-1:0]   o_addr_0,
   output logic [WQE_WIDTH-1:0]             o_din_0,
   output logic [PWQE_SLOT_NUM-1:0]         o_slot_status,
   input  logic                             i_issue,
   input  logic [PWQE_BUF_ADDR_WIDTH-1:0]   i_issue_addr,
   input  logic                             i_wb,
   input  logic [PWQE_BUF_ADDR_WIDTH-1:0]   i_wb_addr,
   input  logic                             i_wb_last,
   output logic [PWQE_BUF_ADDR_WIDTH:0]     o_free_cnt,
   output logic                             o_full,
   output logic                             o_err
);

   localparam logic [1:0] c_free     = 2'd0;
   localparam logic [1:0] c_filling  = 2'd1;
   localparam logic [1:0] c_ready    = 2'd2;
   localparam logic [1:0] c_inflight = 2'd3;
   localparam int         c_cnt_w    = PWQE_BUF_ADDR_WIDTH + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2
   } fill_state_t;

   fill_state_t                      r_state;
   logic [1:0]                       r_slot     [PWQE_SLOT_NUM];
   logic [1:0]                       w_slot_nxt [PWQE_SLOT_NUM];
   logic [PWQE_BUF_ADDR_WIDTH-1:0]   r_addr;
   logic [PWQE_BUF_ADDR_WIDTH-1:0]   w_sel;
   logic                             r_ren;
   logic                             r_wen;
   logic                             r_err;
   logic [PWQE_SLOT_NUM-1:0]         r_status;
   logic [c_cnt_w-1:0]               r_free_cnt;
   logic [c_cnt_w-1:0]               w_free_nxt;
   logic                             w_free_any;
   logic                             w_start;
   logic                             w_alloc;
   logic                             w_done;
   logic                             w_same;
   logic                             w_iss_ok;
   logic                             w_wb_ok;
   logic                             w_err_evt;

   // Lowest-index FREE slot, judged on pre-edge state so a slot released by
   // writeback this cycle is only eligible from the next cycle.
   always_comb begin
      w_free_any = 1'b0;
      w_sel      = '0;
      for (int i = PWQE_SLOT_NUM - 1; i >= 0; i--) begin
         if (r_slot[i] == c_free) begin
            w_free_any = 1'b1;
            w_sel      = PWQE_BUF_ADDR_WIDTH'(i);
         end
      end
   end

   assign w_start   = i_fill_en & ~i_bs_wqe_empty & w_free_any;
   assign w_alloc   = ((r_state == S_IDLE) || (r_state == S_WR)) && w_start;
   assign w_done    = (r_state == S_WR);

   assign w_same    = i_issue & i_wb & (i_issue_addr == i_wb_addr);
   assign w_iss_ok  = i_issue & ~w_same & (r_slot[i_issue_addr] == c_ready);
   assign w_wb_ok   = i_wb & ~w_same & (r_slot[i_wb_addr] == c_inflight);
   assign w_err_evt = w_same
                    | (i_issue & ~w_same & ~w_iss_ok)
                    | (i_wb & ~w_same & ~w_wb_ok);

   always_comb begin
      w_free_nxt = '0;
      for (int i = 0; i < PWQE_SLOT_NUM; i++) begin
         w_slot_nxt[i] = r_slot[i];
         if (w_alloc && (w_sel == PWQE_BUF_ADDR_WIDTH'(i)))
            w_slot_nxt[i] = c_filling;
         if (w_done && (r_addr == PWQE_BUF_ADDR_WIDTH'(i)))
            w_slot_nxt[i] = c_ready;
         if (w_iss_ok && (i_issue_addr == PWQE_BUF_ADDR_WIDTH'(i)))
            w_slot_nxt[i] = c_inflight;
         if (w_wb_ok && (i_wb_addr == PWQE_BUF_ADDR_WIDTH'(i)))
            w_slot_nxt[i] = i_wb_last ? c_free : c_ready;
         if (w_slot_nxt[i] == c_free)
            w_free_nxt = w_free_nxt + c_cnt_w'(1);
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         for (int i = 0; i < PWQE_SLOT_NUM; i++)
            r_slot[i] <= c_free;
         r_status   <= '0;
         r_free_cnt <= c_cnt_w'(PWQE_SLOT_NUM);
         r_err      <= 1'b0;
      end else begin
         for (int i = 0; i < PWQE_SLOT_NUM; i++) begin
            r_slot[i]   <= w_slot_nxt[i];
            r_status[i] <= (w_slot_nxt[i] == c_ready);
         end
         r_free_cnt <= w_free_nxt;
         if (w_err_evt)
            r_err <= 1'b1;
      end
   end

   // Fill FSM: RD pops the FIFO, WR writes the popped word one cycle later.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state <= S_IDLE;
         r_ren   <= 1'b0;
         r_wen   <= 1'b0;
         r_addr  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_state <= S_RD;
                  r_ren   <= 1'b1;
                  r_addr  <= w_sel;
               end
            end
            S_RD: begin
               r_state <= S_WR;
               r_ren   <= 1'b0;
               r_wen   <= 1'b1;
            end
            S_WR: begin
               r_wen <= 1'b0;
               if (w_start) begin
                  r_state <= S_RD;
                  r_ren   <= 1'b1;
                  r_addr  <= w_sel;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_ren   <= 1'b0;
               r_wen   <= 1'b0;
            end
         endcase
      end
   end

   assign o_bs_wqe_ren  = r_ren;
   assign o_wen_0       = r_wen;
   assign o_addr_0      = r_addr;
   assign o_din_0       = i_bs_wqe_rdata;
   assign o_slot_status = r_status;
   assign o_free_cnt    = r_free_cnt;
   assign o_full        = (r_free_cnt == '0);
   assign o_err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pwqe_slot_mgr.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwqe_slot_mgr
// Purpose  : Self-checking bench for pwqe_slot_mgr with a 1-cycle-latency FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwqe_slot_mgr;

   localparam int WQE_WIDTH = 512;
   localparam int SLOTS     = 4;
   localparam int AW        = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 fill_en;
   logic                 bs_empty;
   logic                 bs_ren;
   logic [WQE_WIDTH-1:0] bs_rdata;
   logic                 wen_0;
   logic [AW-1:0]        addr_0;
   logic [WQE_WIDTH-1:0] din_0;
   logic [SLOTS-1:0]     slot_status;
   logic                 issue;
   logic [AW-1:0]        issue_addr;
   logic                 wb;
   logic [AW-1:0]        wb_addr;
   logic                 wb_last;
   logic [AW:0]          free_cnt;
   logic                 full;
   logic                 err;

   always #5 clk = ~clk;

   pwqe_slot_mgr #(
      .WQE_WIDTH           (WQE_WIDTH),
      .PWQE_SLOT_NUM       (SLOTS),
      .PWQE_BUF_ADDR_WIDTH (AW)
   ) dut (
      .sys_clk        (clk),
      .sys_rst        (rst),
      .i_fill_en      (fill_en),
      .i_bs_wqe_empty (bs_empty),
      .o_bs_wqe_ren   (bs_ren),
      .i_bs_wqe_rdata (bs_rdata),
      .o_wen_0        (wen_0),
      .o_addr_0       (addr_0),
      .o_din_0        (din_0),
      .o_slot_status  (slot_status),
      .i_issue        (issue),
      .i_issue_addr   (issue_addr),
      .i_wb           (wb),
      .i_wb_addr      (wb_addr),
      .i_wb_last      (wb_last),
      .o_free_cnt     (free_cnt),
      .o_full         (full),
      .o_err          (err)
   );

   // FIFO model: main thread owns wp, the read process owns rp.
   logic [WQE_WIDTH-1:0] fifo_mem [16];
   int                   wp = 0;
   int                   rp = 0;
   assign bs_empty = (wp == rp);

   always @(posedge clk) begin
      if (bs_ren && (rp != wp)) begin
         bs_rdata <= fifo_mem[rp % 16];
         rp       <= rp + 1;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [AW-1:0]        addr;
      logic [WQE_WIDTH-1:0] data;
      int                   c;
   } wr_t;

   wr_t sb  [$];
   wr_t obs [$];

   always @(negedge clk) begin
      if (wen_0 === 1'b1) begin
         wr_t o;
         o.addr = addr_0;
         o.data = din_0;
         o.c    = cyc;
         obs.push_back(o);
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [WQE_WIDTH-1:0] mk(input int k);
      logic [31:0] w;
      w  = 32'hC0DE_0000 | 32'(k);
      mk = {16{w}};
   endfunction

   task automatic post_wqe(input int k, input logic [AW-1:0] slot);
      wr_t e;
      fifo_mem[wp % 16] = mk(k);
      wp                = wp + 1;
      e.addr            = slot;
      e.data            = mk(k);
      e.c               = 0;
      sb.push_back(e);
   endtask

   task automatic drain(input string name);
      wr_t e;
      wr_t o;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (obs.size() == 0) begin
            chk({name, "_missing_write"}, 32'd0, 32'd1);
         end else begin
            o = obs.pop_front();
            chk({name, "_wr_addr"}, 32'(o.addr), 32'(e.addr));
            n_tests++;
            if (o.data !== e.data) begin
               n_fail++;
               $display("FAIL %s_wr_data: got %h expected %h", name, o.data[63:0], e.data[63:0]);
            end
         end
      end
      chk({name, "_extra_writes"}, 32'(obs.size()), 32'd0);
      obs.delete();
   endtask

   task automatic wait_status(input logic [SLOTS-1:0] exp, input string name);
      int k;
      k = 0;
      while (slot_status !== exp && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk(name, 32'(slot_status), 32'(exp));
   endtask

   // One issue/writeback pulse, then settle to the next negedge.
   task automatic op(input logic iss, input logic [AW-1:0] ia,
                     input logic w, input logic [AW-1:0] wa, input logic wl);
      issue      = iss;
      issue_addr = ia;
      wb         = w;
      wb_addr    = wa;
      wb_last    = wl;
      @(posedge clk);
      #1;
      issue = 1'b0;
      wb    = 1'b0;
      @(negedge clk);
   endtask

   typedef struct {
      logic             iss;
      logic [AW-1:0]    ia;
      logic             w;
      logic [AW-1:0]    wa;
      logic             wl;
      logic [SLOTS-1:0] st;
      logic [AW:0]      fc;
      logic             er;
   } vec_t;

   vec_t vt [7];

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ren"},    32'(bs_ren),      32'd0);
      chk({tag, "_wen"},    32'(wen_0),       32'd0);
      chk({tag, "_addr"},   32'(addr_0),      32'd0);
      chk({tag, "_status"}, 32'(slot_status), 32'd0);
      chk({tag, "_free"},   32'(free_cnt),    32'd4);
      chk({tag, "_full"},   32'(full),        32'd0);
      chk({tag, "_err"},    32'(err),         32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int k;
      vt[0] = '{1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 4'b1011, 3'd0, 1'b0};
      vt[1] = '{1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 4'b1111, 3'd0, 1'b0};
      vt[2] = '{1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 4'b1011, 3'd0, 1'b0};
      vt[3] = '{1'b0, 2'd0, 1'b1, 2'd2, 1'b1, 4'b1011, 3'd1, 1'b0};
      vt[4] = '{1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 4'b1010, 3'd1, 1'b0};
      vt[5] = '{1'b1, 2'd1, 1'b1, 2'd0, 1'b0, 4'b1001, 3'd1, 1'b0};
      vt[6] = '{1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 4'b1011, 3'd1, 1'b0};

      rst        = 1'b0;
      fill_en    = 1'b0;
      issue      = 1'b0;
      issue_addr = '0;
      wb         = 1'b0;
      wb_addr    = '0;
      wb_last    = 1'b0;
      #1 rst = 1'b1;
      #1 chk_reset_vals("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Fill four slots from a five-deep FIFO.
      for (int i = 0; i < 5; i++) begin
         fifo_mem[wp % 16] = mk(i);
         wp                = wp + 1;
      end
      for (int i = 0; i < 4; i++) begin
         wr_t e;
         e.addr = AW'(i);
         e.data = mk(i);
         e.c    = 0;
         sb.push_back(e);
      end
      fill_en = 1'b1;
      wait_status(4'b1111, "fill_status");
      fill_en = 1'b0;
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_free", 32'(free_cnt), 32'd0);
      chk("fill_fifo_left", 32'(wp - rp), 32'd1);
      chk("fill_nwrites", 32'(obs.size()), 32'd4);
      if (obs.size() == 4) begin
         for (int i = 0; i < 3; i++)
            chk($sformatf("fill_spacing%0d", i), 32'(obs[i+1].c - obs[i].c), 32'd2);
      end
      drain("fill");

      // Dispatch / writeback vectors.
      for (int i = 0; i < 7; i++) begin
         op(vt[i].iss, vt[i].ia, vt[i].w, vt[i].wa, vt[i].wl);
         chk($sformatf("vec%0d_status", i), 32'(slot_status), 32'(vt[i].st));
         chk($sformatf("vec%0d_free", i),   32'(free_cnt),    32'(vt[i].fc));
         chk($sformatf("vec%0d_full", i),   32'(full),        32'(vt[i].fc == 0));
         chk($sformatf("vec%0d_err", i),    32'(err),         32'(vt[i].er));
      end

      // Freed slot 2 receives the remaining FIFO word.
      begin
         wr_t e;
         e.addr = 2'd2;
         e.data = mk(4);
         e.c    = 0;
         sb.push_back(e);
      end
      fill_en = 1'b1;
      wait_status(4'b1111, "refill_status");
      chk("refill_free", 32'(free_cnt), 32'd0);
      drain("refill");

      // Free/allocate race on slot 1.
      op(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
      chk("race_pre_status", 32'(slot_status), 32'b1101);
      post_wqe(5, 2'd1);
      wb      = 1'b1;
      wb_addr = 2'd1;
      wb_last = 1'b1;
      @(posedge clk);
      #1 wb = 1'b0;
      @(negedge clk);
      chk("race_no_rd_yet", 32'(bs_ren), 32'd0);
      chk("race_free", 32'(free_cnt), 32'd1);
      @(negedge clk);
      chk("race_rd", 32'(bs_ren), 32'd1);
      chk("race_addr", 32'(addr_0), 32'd1);
      wait_status(4'b1111, "race_status");
      drain("race");
      fill_en = 1'b0;

      // Issue to a FREE slot.
      op(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
      op(1'b0, 2'd0, 1'b1, 2'd3, 1'b1);
      chk("freeiss_pre_err", 32'(err), 32'd0);
      chk("freeiss_pre_status", 32'(slot_status), 32'b0111);
      op(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
      chk("freeiss_err", 32'(err), 32'd1);
      chk("freeiss_status", 32'(slot_status), 32'b0111);
      chk("freeiss_free", 32'(free_cnt), 32'd1);

      // Reset during WR.
      post_wqe(6, 2'd3);
      fill_en = 1'b1;
      k = 0;
      while (wen_0 !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("rstwr_wen_seen", 32'(wen_0), 32'd1);
      #2 rst = 1'b1;
      fill_en = 1'b0;
      #1 chk_reset_vals("rstwr");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rstwr_next_wen", 32'(wen_0), 32'd0);
      chk("rstwr_next_free", 32'(free_cnt), 32'd4);
      drain("rstwr");

      // Same-slot issue and writeback.
      post_wqe(7, 2'd0);
      fill_en = 1'b1;
      wait_status(4'b0001, "conf_fill_status");
      fill_en = 1'b0;
      drain("conf");
      op(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
      chk("conf_pre_status", 32'(slot_status), 32'b0000);
      chk("conf_pre_err", 32'(err), 32'd0);
      op(1'b1, 2'd0, 1'b1, 2'd0, 1'b0);
      chk("conf_err", 32'(err), 32'd1);
      chk("conf_status", 32'(slot_status), 32'b0000);
      chk("conf_free", 32'(free_cnt), 32'd3);
      op(1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
      chk("conf_still_inflight", 32'(slot_status), 32'b0001);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
